// File: rtl/md_cmd_issuer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// md_cmd_issuer_if : command, engine and result signals of md_cmd_issuer
// Rev 1.0
// ----------------------------------------------------------------------------
interface md_cmd_issuer_if #(
    parameter int SIZE_A = 128,
    parameter int SIZE_B = 64,
    parameter int TAG_W  = 4
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_select;
    logic [SIZE_A-1:0]        cmd_a;
    logic [SIZE_B-1:0]        cmd_b;
    logic [TAG_W-1:0]         cmd_tag;

    logic                     md_en;
    logic                     md_select;
    logic [SIZE_A-1:0]        md_a;
    logic [SIZE_B-1:0]        md_b;
    logic [SIZE_A+SIZE_B-1:0] md_p;
    logic                     md_valid;
    logic                     md_busy;

    logic                     res_valid;
    logic                     res_ready;
    logic [SIZE_A+SIZE_B-1:0] res_p;
    logic                     res_select;
    logic [TAG_W-1:0]         res_tag;
    logic                     res_err;

    modport slave (
        input  cmd_valid, cmd_select, cmd_a, cmd_b, cmd_tag,
        input  md_p, md_valid, md_busy, res_ready,
        output cmd_ready, md_en, md_select, md_a, md_b,
        output res_valid, res_p, res_select, res_tag, res_err
    );

    modport master (
        output cmd_valid, cmd_select, cmd_a, cmd_b, cmd_tag,
        output md_p, md_valid, md_busy, res_ready,
        input  cmd_ready, md_en, md_select, md_a, md_b,
        input  res_valid, res_p, res_select, res_tag, res_err
    );
endinterface
`default_nettype wire

// File: rtl/md_cmd_issuer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// md_cmd_issuer : FIFO-buffered mul/div issuer for multi_div; MD_TIMEOUT_EN adds a WAIT watchdog
// Rev 1.0
// ----------------------------------------------------------------------------
module md_cmd_issuer #(
    parameter int SIZE_A     = 128,
    parameter int SIZE_B     = 64,
    parameter int FAST_MODE  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int TIMEOUT    = 1023
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    md_cmd_issuer_if.slave bus
);
    localparam int c_PW = SIZE_A + SIZE_B;
    localparam int c_EW = 1 + TAG_W + SIZE_A + SIZE_B;
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_N  = SIZE_A / FAST_MODE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW:0]   r_wr_ptr, r_rd_ptr;
    logic            w_empty, w_full, w_push, w_issue;
    logic [c_EW-1:0] w_head;

    logic             r_cur_sel, r_hold_err;
    logic [TAG_W-1:0] r_cur_tag;
    logic [c_PW-1:0]  r_hold_p, w_md_res, w_ld_p;
    logic             w_ld_err, w_load, w_capture, w_slot_free, w_tmo;
    logic             r_res_valid, r_res_sel, r_res_err;
    logic [c_PW-1:0]  r_res_p;
    logic [TAG_W-1:0] r_res_tag;

    // Engine latency (N) only constrains TIMEOUT; no logic here depends on it.
    wire logic w_unused_cfg = (c_N > TIMEOUT);

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_push  = bus.cmd_valid && bus.cmd_ready;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign bus.cmd_ready = !w_full || w_issue;

    assign bus.md_en     = w_issue;
    assign bus.md_select = w_issue & w_head[c_EW-1];
    assign bus.md_a      = w_issue ? w_head[SIZE_A+SIZE_B-1:SIZE_B] : '0;
    assign bus.md_b      = w_issue ? w_head[SIZE_B-1:0] : '0;

    assign w_slot_free = !r_res_valid || bus.res_ready;
    assign w_md_res    = r_cur_sel ? {{SIZE_B{1'b0}}, bus.md_p[SIZE_A-1:0]} : bus.md_p;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_issue)
                r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[c_AW-1:0]] <= {bus.cmd_select, bus.cmd_tag, bus.cmd_a, bus.cmd_b};
    end

`ifdef MD_TIMEOUT_EN
    localparam int c_CW = $clog2(TIMEOUT + 1);
    logic [c_CW-1:0] r_cnt;

    // r_cnt equals the number of cycles since md_en; a same-cycle md_valid wins.
    assign w_tmo = (r_state == S_WAIT) && !bus.md_valid && (r_cnt == c_CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (w_issue)
            r_cnt <= c_CW'(1);
        else if (r_state == S_WAIT)
            r_cnt <= r_cnt + c_CW'(1);
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_ld_p      = '0;
        w_ld_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !bus.md_busy) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.md_valid || w_tmo) begin
                    w_ld_p   = w_tmo ? '0 : w_md_res;
                    w_ld_err = w_tmo;
                    if (w_slot_free) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                w_ld_p   = r_hold_p;
                w_ld_err = r_hold_err;
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cur_sel   <= 1'b0;
            r_cur_tag   <= '0;
            r_hold_p    <= '0;
            r_hold_err  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_p     <= '0;
            r_res_sel   <= 1'b0;
            r_res_tag   <= '0;
            r_res_err   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_cur_sel <= w_head[c_EW-1];
                r_cur_tag <= w_head[c_EW-2 -: TAG_W];
            end
            if (w_capture) begin
                r_hold_p   <= w_ld_p;
                r_hold_err <= w_ld_err;
            end
            if (w_load) begin
                r_res_valid <= 1'b1;
                r_res_p     <= w_ld_p;
                r_res_sel   <= r_cur_sel;
                r_res_tag   <= r_cur_tag;
                r_res_err   <= w_ld_err;
            end else if (bus.res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign bus.res_valid  = r_res_valid;
    assign bus.res_p      = r_res_p;
    assign bus.res_select = r_res_sel;
    assign bus.res_tag    = r_res_tag;
    assign bus.res_err    = r_res_err;
endmodule
`default_nettype wire
